reg_file_mp: RTL and testbench

- Next-generation parametrised register file for the datapath.
- Adds the following over the single-write, two-read file:
  - NR combinational read ports.
  - Two write ports with fixed priority.
  - A configurable hardwired-zero register and a configurable read-only register.
  - A sequential clear engine that sweeps every register to zero on request.
- Sits between decode (read addresses), writeback (write ports) and the controller (clear request).

---
 rtl/reg_file_mp.sv | 111 +++++++++++
 tb/tb_reg_file_mp.sv | 361 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_file_mp.sv
// Multi-port register file: NR combinational reads, two prioritised writes,
// hardwired-zero and read-only slots, sequential clear sweep. Optional
// same-cycle write forwarding under REG_FILE_MP_BYPASS_EN.
module reg_file_mp #(
  parameter int unsigned W        = 8,
  parameter int unsigned D        = 4,
  parameter int unsigned NR       = 2,
  parameter int unsigned ZERO_IDX = 2**D-1,
  parameter int unsigned RO_IDX   = 2**D-2
) (
  input  logic            CLK,
  input  logic            Reset_n,
  input  logic            WrEn0,
  input  logic [D-1:0]    WrAddr0,
  input  logic [W-1:0]    WrData0,
  input  logic            WrEn1,
  input  logic [D-1:0]    WrAddr1,
  input  logic [W-1:0]    WrData1,
  input  logic [NR*D-1:0] RdAddr,
  output logic [NR*W-1:0] RdData,
  input  logic            ClrReq,
  output logic            ClrBusy,
  output logic            WrDrop
);

  localparam int unsigned N = 2**D;
  localparam logic [D-1:0] ZERO_A = D'(ZERO_IDX);
  localparam logic [D-1:0] RO_A   = D'(RO_IDX);
  localparam logic [D-1:0] LAST_A = D'(N-1);

  typedef enum logic {IDLE, CLEAR} state_e;

  state_e         state_q;
  logic [W-1:0]   mem_q [N];
  logic [D-1:0]   cnt_q;
  logic [D-1:0]   cnt_d;
  logic           clr_busy_q;
  logic           wr_drop_q;
  logic           wr_drop_d;
  logic           ok0_c;
  logic           ok1_c;
  logic           eff0_c;
  logic           eff1_c;

  // A write is "ok" if it targets a writable slot; it only lands while idle.
  assign ok0_c     = WrEn0 && (WrAddr0 != ZERO_A) && (WrAddr0 != RO_A);
  assign ok1_c     = WrEn1 && (WrAddr1 != ZERO_A) && (WrAddr1 != RO_A);
  assign eff0_c    = ok0_c && (state_q == IDLE);
  assign eff1_c    = ok1_c && (state_q == IDLE);
  assign wr_drop_d = (state_q == CLEAR) && (ok0_c || ok1_c);
  assign cnt_d     = cnt_q + D'(1);

  always_ff @(posedge CLK) begin
    if (!Reset_n) begin
      mem_q      <= '{default: '0};
      state_q    <= IDLE;
      cnt_q      <= '0;
      clr_busy_q <= 1'b0;
      wr_drop_q  <= 1'b0;
    end else begin
      wr_drop_q <= wr_drop_d;
      case (state_q)
        IDLE: begin
          // Port 1 assigned last so it wins on an address collision.
          if (eff0_c) mem_q[WrAddr0] <= WrData0;
          if (eff1_c) mem_q[WrAddr1] <= WrData1;
          if (ClrReq) begin
            state_q    <= CLEAR;
            cnt_q      <= '0;
            clr_busy_q <= 1'b1;
          end
        end
        CLEAR: begin
          mem_q[cnt_q] <= '0;
          if (cnt_q == LAST_A) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            clr_busy_q <= 1'b0;
          end else begin
            cnt_q <= cnt_d;
          end
        end
      endcase
    end
  end

  assign ClrBusy = clr_busy_q;
  assign WrDrop  = wr_drop_q;

  for (genvar k = 0; k < NR; k++) begin : g_rd
    logic [D-1:0] addr_c;
    logic [W-1:0] word_c;

    assign addr_c = RdAddr[k*D +: D];

    always_comb begin
      word_c = mem_q[addr_c];
`ifdef REG_FILE_MP_BYPASS_EN
      if (eff1_c && (WrAddr1 == addr_c)) begin
        word_c = WrData1;
      end else if (eff0_c && (WrAddr0 == addr_c)) begin
        word_c = WrData0;
      end
`endif
      if (addr_c == ZERO_A) word_c = '0;
    end

    assign RdData[k*W +: W] = word_c;
  end

endmodule

// File: tb/tb_reg_file_mp.sv
// Self-checking bench for reg_file_mp (W=8, D=4, NR=2) against a behavioural
// model of register contents and clear-sweep progress.
module tb_reg_file_mp;

  logic        CLK;
  logic        Reset_n;
  logic        WrEn0;
  logic [3:0]  WrAddr0;
  logic [7:0]  WrData0;
  logic        WrEn1;
  logic [3:0]  WrAddr1;
  logic [7:0]  WrData1;
  logic [7:0]  RdAddr;
  logic [15:0] RdData;
  logic        ClrReq;
  logic        ClrBusy;
  logic        WrDrop;

  reg_file_mp #(.W(8), .D(4), .NR(2)) dut (
    .CLK(CLK), .Reset_n(Reset_n),
    .WrEn0(WrEn0), .WrAddr0(WrAddr0), .WrData0(WrData0),
    .WrEn1(WrEn1), .WrAddr1(WrAddr1), .WrData1(WrData1),
    .RdAddr(RdAddr), .RdData(RdData),
    .ClrReq(ClrReq), .ClrBusy(ClrBusy), .WrDrop(WrDrop)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Reference model: contents, sweep position (-1 = idle), flags.
  logic [7:0] m [16];
  int         sweep;
  bit         m_busy;
  bit         m_drop;
  int         errors;
  int         checks;

  function automatic bit writable(input logic en, input logic [3:0] a);
    return (en === 1'b1) && (a != 4'd15) && (a != 4'd14);
  endfunction

  function automatic logic [7:0] exp_rd(input logic [3:0] a);
    if (a == 4'd15) return 8'h00;
`ifdef REG_FILE_MP_BYPASS_EN
    if (sweep < 0 && writable(WrEn1, WrAddr1) && WrAddr1 == a) return WrData1;
    if (sweep < 0 && writable(WrEn0, WrAddr0) && WrAddr0 == a) return WrData0;
`endif
    return m[a];
  endfunction

  task automatic model_step();
    bit v0, v1;
    v0 = writable(WrEn0, WrAddr0);
    v1 = writable(WrEn1, WrAddr1);
    if (Reset_n !== 1'b1) begin
      for (int i = 0; i < 16; i++) m[i] = 8'h00;
      sweep  = -1;
      m_busy = 1'b0;
      m_drop = 1'b0;
    end else if (sweep < 0) begin
      m_drop = 1'b0;
      if (v0) m[WrAddr0] = WrData0;
      if (v1) m[WrAddr1] = WrData1;
      if (ClrReq === 1'b1) begin
        sweep  = 0;
        m_busy = 1'b1;
      end
    end else begin
      m_drop   = v0 || v1;
      m[sweep] = 8'h00;
      sweep++;
      if (sweep == 16) begin
        sweep  = -1;
        m_busy = 1'b0;
      end
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge CLK);
    #1;
  endtask

  task automatic quiet();
    Reset_n = 1'b1;
    WrEn0   = 1'b0;
    WrEn1   = 1'b0;
    ClrReq  = 1'b0;
  endtask

  task automatic test_reset();
    Reset_n = 1'b0; ClrReq = 1'b1;
    WrEn0 = 1'b1; WrAddr0 = 4'd3; WrData0 = 8'($urandom);
    WrEn1 = 1'b1; WrAddr1 = 4'd4; WrData1 = 8'($urandom);
    RdAddr = 8'h00;
    tick();
    quiet();
    for (int i = 0; i < 16; i += 2) begin
      RdAddr = {4'(i + 1), 4'(i)};
      #1;
      checks += 2;
      if (RdData[7:0] !== 8'h00) begin
        errors++; $display("FAIL reset_rd addr %0d: got %02h want 00", i, RdData[7:0]);
      end
      if (RdData[15:8] !== 8'h00) begin
        errors++; $display("FAIL reset_rd addr %0d: got %02h want 00", i + 1, RdData[15:8]);
      end
    end
    checks += 2;
    if (ClrBusy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", ClrBusy); end
    if (WrDrop !== 1'b0) begin errors++; $display("FAIL reset_drop: got %b want 0", WrDrop); end
  endtask

  task automatic test_dual_write();
    WrEn0 = 1'b1; WrAddr0 = 4'd3; WrData0 = 8'hA5;
    WrEn1 = 1'b1; WrAddr1 = 4'd3; WrData1 = 8'h5A;
    tick();
    quiet();
    RdAddr = {4'd4, 4'd3};
    #1;
    checks++;
    if (RdData[7:0] !== 8'h5A) begin
      errors++; $display("FAIL dual_same addr3: got %02h want 5a", RdData[7:0]);
    end
    WrEn0 = 1'b1; WrAddr0 = 4'd3; WrData0 = 8'hA5;
    WrEn1 = 1'b1; WrAddr1 = 4'd4; WrData1 = 8'h5A;
    tick();
    quiet();
    #1;
    checks += 2;
    if (RdData[7:0] !== 8'hA5) begin
      errors++; $display("FAIL dual_diff addr3: got %02h want a5", RdData[7:0]);
    end
    if (RdData[15:8] !== 8'h5A) begin
      errors++; $display("FAIL dual_diff addr4: got %02h want 5a", RdData[15:8]);
    end
  endtask

  task automatic test_protected();
    WrEn0 = 1'b1; WrAddr0 = 4'd15; WrData0 = 8'hFF;
    WrEn1 = 1'b1; WrAddr1 = 4'd14; WrData1 = 8'hFF;
    RdAddr = {4'd14, 4'd15};
    #1;
    checks += 2;
    if (RdData[7:0] !== exp_rd(4'd15)) begin
      errors++; $display("FAIL prot_same15: got %02h want %02h", RdData[7:0], exp_rd(4'd15));
    end
    if (RdData[15:8] !== exp_rd(4'd14)) begin
      errors++; $display("FAIL prot_same14: got %02h want %02h", RdData[15:8], exp_rd(4'd14));
    end
    tick();
    quiet();
    #1;
    checks += 3;
    if (RdData[7:0] !== 8'h00) begin
      errors++; $display("FAIL prot_addr15: got %02h want 00", RdData[7:0]);
    end
    if (RdData[15:8] !== 8'h00) begin
      errors++; $display("FAIL prot_addr14: got %02h want 00", RdData[15:8]);
    end
    if (WrDrop !== 1'b0) begin errors++; $display("FAIL prot_drop: got %b want 0", WrDrop); end
  endtask

  task automatic test_clear_sweep();
    int n;
    for (int i = 0; i < 14; i += 2) begin
      WrEn0 = 1'b1; WrAddr0 = 4'(i);     WrData0 = 8'(8'h10 + i);
      WrEn1 = 1'b1; WrAddr1 = 4'(i + 1); WrData1 = 8'(8'h11 + i);
      tick();
    end
    quiet();
    ClrReq = 1'b1;
    tick();
    ClrReq = 1'b0;
    n = 0;
    while (ClrBusy === 1'b1 && n < 40) begin
      RdAddr = {4'(n == 0 ? 0 : n - 1), 4'(n)};
      #1;
      checks += 2;
      if (RdData[7:0] !== exp_rd(4'(n))) begin
        errors++; $display("FAIL sweep_pending step %0d: got %02h want %02h", n, RdData[7:0], exp_rd(4'(n)));
      end
      if (RdData[15:8] !== exp_rd(RdAddr[7:4])) begin
        errors++; $display("FAIL sweep_zeroed step %0d: got %02h want %02h", n, RdData[15:8], exp_rd(RdAddr[7:4]));
      end
      tick();
      n++;
    end
    checks++;
    if (n != 16) begin errors++; $display("FAIL sweep_len: got %0d want 16", n); end
    for (int i = 0; i < 16; i += 2) begin
      RdAddr = {4'(i + 1), 4'(i)};
      #1;
      checks += 2;
      if (RdData[7:0] !== 8'h00) begin
        errors++; $display("FAIL sweep_after addr %0d: got %02h want 00", i, RdData[7:0]);
      end
      if (RdData[15:8] !== 8'h00) begin
        errors++; $display("FAIL sweep_after addr %0d: got %02h want 00", i + 1, RdData[15:8]);
      end
    end
  endtask

  task automatic test_write_during_sweep();
    int n;
    WrEn0 = 1'b1; WrAddr0 = 4'd2; WrData0 = 8'h33;
    tick();
    quiet();
    ClrReq = 1'b1;
    tick();
    ClrReq = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    WrEn0 = 1'b1; WrAddr0 = 4'd2; WrData0 = 8'h77;
    tick();
    WrEn0 = 1'b0;
    checks++;
    if (WrDrop !== 1'b1 || m_drop !== 1'b1) begin
      errors++; $display("FAIL drop_set: got %b want 1", WrDrop);
    end
    tick();
    checks++;
    if (WrDrop !== 1'b0) begin errors++; $display("FAIL drop_clear: got %b want 0", WrDrop); end
    n = 0;
    while (ClrBusy === 1'b1 && n < 40) begin tick(); n++; end
    checks++;
    if (ClrBusy !== 1'b0) begin errors++; $display("FAIL drop_sweep_end: busy %b want 0", ClrBusy); end
    RdAddr = {4'd0, 4'd2};
    #1;
    checks++;
    if (RdData[7:0] !== 8'h00) begin
      errors++; $display("FAIL drop_lost addr2: got %02h want 00", RdData[7:0]);
    end
  endtask

  task automatic test_reset_mid_sweep();
    for (int i = 0; i < 14; i++) begin
      WrEn0 = 1'b1; WrAddr0 = 4'(i); WrData0 = 8'($urandom_range(1, 255));
      tick();
    end
    quiet();
    ClrReq = 1'b1;
    tick();
    ClrReq = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    Reset_n = 1'b0;
    tick();
    Reset_n = 1'b1;
    checks += 2;
    if (ClrBusy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b want 0", ClrBusy); end
    if (WrDrop !== 1'b0) begin errors++; $display("FAIL rstmid_drop: got %b want 0", WrDrop); end
    for (int i = 0; i < 16; i += 2) begin
      RdAddr = {4'(i + 1), 4'(i)};
      #1;
      checks += 2;
      if (RdData[7:0] !== 8'h00) begin
        errors++; $display("FAIL rstmid_rd addr %0d: got %02h want 00", i, RdData[7:0]);
      end
      if (RdData[15:8] !== 8'h00) begin
        errors++; $display("FAIL rstmid_rd addr %0d: got %02h want 00", i + 1, RdData[15:8]);
      end
    end
    tick();
    checks++;
    if (ClrBusy !== 1'b0) begin errors++; $display("FAIL rstmid_abort: busy %b want 0", ClrBusy); end
  endtask

  task automatic test_held_clrreq();
    int n;
    ClrReq = 1'b1;
    tick();
    n = 0;
    while (ClrBusy === 1'b1 && n < 40) begin tick(); n++; end
    checks += 3;
    if (n != 16) begin errors++; $display("FAIL held_len: got %0d want 16", n); end
    if (ClrBusy !== 1'b0) begin errors++; $display("FAIL held_gap: busy %b want 0", ClrBusy); end
    tick();
    if (ClrBusy !== 1'b1) begin errors++; $display("FAIL held_restart: busy %b want 1", ClrBusy); end
    ClrReq = 1'b0;
    n = 0;
    while (ClrBusy === 1'b1 && n < 40) begin tick(); n++; end
    checks++;
    if (n != 16) begin errors++; $display("FAIL held_len2: got %0d want 16", n); end
  endtask

  task automatic test_bypass();
    quiet();
    WrEn0 = 1'b1; WrAddr0 = 4'd6; WrData0 = 8'h3C;
    RdAddr = {4'd7, 4'd6};
    #1;
    checks++;
    if (RdData[7:0] !== exp_rd(4'd6)) begin
      errors++; $display("FAIL byp_same addr6: got %02h want %02h", RdData[7:0], exp_rd(4'd6));
    end
    tick();
    WrEn0 = 1'b1; WrAddr0 = 4'd7; WrData0 = 8'h11;
    WrEn1 = 1'b1; WrAddr1 = 4'd7; WrData1 = 8'h22;
    #1;
    checks += 2;
    if (RdData[7:0] !== 8'h3C) begin
      errors++; $display("FAIL byp_next addr6: got %02h want 3c", RdData[7:0]);
    end
    if (RdData[15:8] !== exp_rd(4'd7)) begin
      errors++; $display("FAIL byp_prio addr7: got %02h want %02h", RdData[15:8], exp_rd(4'd7));
    end
    tick();
    quiet();
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      Reset_n = ($urandom_range(0, 149) != 0);
      ClrReq  = ($urandom_range(0, 29) == 0);
      WrEn0 = 1'($urandom); WrAddr0 = 4'($urandom); WrData0 = 8'($urandom);
      WrEn1 = 1'($urandom); WrAddr1 = 4'($urandom); WrData1 = 8'($urandom);
      RdAddr = 8'($urandom);
      #1;
      checks += 4;
      if (RdData[7:0] !== exp_rd(RdAddr[3:0])) begin
        errors++; $display("FAIL rand_rd0 cyc %0d addr %0d: got %02h want %02h", c, RdAddr[3:0], RdData[7:0], exp_rd(RdAddr[3:0]));
      end
      if (RdData[15:8] !== exp_rd(RdAddr[7:4])) begin
        errors++; $display("FAIL rand_rd1 cyc %0d addr %0d: got %02h want %02h", c, RdAddr[7:4], RdData[15:8], exp_rd(RdAddr[7:4]));
      end
      if (ClrBusy !== m_busy) begin
        errors++; $display("FAIL rand_busy cyc %0d: got %b want %b", c, ClrBusy, m_busy);
      end
      if (WrDrop !== m_drop) begin
        errors++; $display("FAIL rand_drop cyc %0d: got %b want %b", c, WrDrop, m_drop);
      end
      tick();
    end
    quiet();
  endtask

  initial begin
    errors = 0;
    checks = 0;
    sweep  = -1;
    m_busy = 1'b0;
    m_drop = 1'b0;
    for (int i = 0; i < 16; i++) m[i] = 8'h00;
    Reset_n = 1'b0; ClrReq = 1'b0; RdAddr = 8'h00;
    WrEn0 = 1'b0; WrAddr0 = 4'd0; WrData0 = 8'h00;
    WrEn1 = 1'b0; WrAddr1 = 4'd0; WrData1 = 8'h00;
    @(posedge CLK);
    #1;
    test_reset();
    test_dual_write();
    test_protected();
    test_clear_sweep();
    test_write_during_sweep();
    test_reset_mid_sweep();
    test_held_clrreq();
    test_bypass();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
